// File: rtl/eth_ram_pkg.sv
// Shared types and defaults for the eth->HDMI line RAM write side.
// Optional statistics are enabled by defining ETH_RAM_PP_STATS_EN.
package eth_ram_pkg;
    localparam int DEFAULT_ADDR_WIDTH = 13;
    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        CLOSE
    } state_t;
endpackage

// File: rtl/eth_ram_bank_tracker.sv
// Ping-pong bank ownership flags and published word counts.
// A bank is handed to the read side on set and returned on release.
module eth_ram_bank_tracker
    import eth_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic                  set_bank,
    input  logic [ADDR_WIDTH-1:0] set_len,
    input  logic [1:0]            bank_release,
    output logic [1:0]            bank_ready,
    output logic [ADDR_WIDTH-1:0] bank_len0,
    output logic [ADDR_WIDTH-1:0] bank_len1
);

    // Set wins over release; the writer never closes a bank the reader holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_ready <= 2'b00;
            bank_len0  <= '0;
            bank_len1  <= '0;
        end else begin
            if (set_en && !set_bank) begin
                bank_ready[0] <= 1'b1;
                bank_len0     <= set_len;
            end else if (bank_release[0]) begin
                bank_ready[0] <= 1'b0;
            end
            if (set_en && set_bank) begin
                bank_ready[1] <= 1'b1;
                bank_len1     <= set_len;
            end else if (bank_release[1]) begin
                bank_ready[1] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/eth_ram_pingpong_ctrl.sv
// Write-side sequencer packing a pixel stream into two ping-pong RAM banks.
// Define ETH_RAM_PP_STATS_EN to add pkt_cnt / ovf_cnt counters.
module eth_ram_pingpong_ctrl
    import eth_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [1:0]            bank_ready,
    output logic [ADDR_WIDTH-1:0] bank_len0,
    output logic [ADDR_WIDTH-1:0] bank_len1,
    input  logic [1:0]            bank_release,
    output logic                  ovf_pulse
`ifdef ETH_RAM_PP_STATS_EN
    ,
    output logic [15:0]           pkt_cnt,
    output logic [15:0]           ovf_cnt
`endif
);

    localparam int OW         = ADDR_WIDTH - 1;
    localparam int BANK_DEPTH = 2 ** OW;
    localparam logic [ADDR_WIDTH-1:0] LAST_OFF =
        ADDR_WIDTH'(BANK_DEPTH - 1);

    state_t                state;
    logic                  cur_bank;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  accept;

    assign s_ready = (state == FILL) || (state == DRAIN);
    assign accept  = s_valid && s_ready;

    // Bank FSM, offset counter and one-stage RAM write register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur_bank    <= 1'b0;
            offset      <= '0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            ovf_pulse   <= 1'b0;
        end else begin
            ram_wr_en <= 1'b0;
            ovf_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!bank_ready[cur_bank])
                        state <= FILL;
                end
                FILL: begin
                    if (accept) begin
                        ram_wr_en   <= 1'b1;
                        ram_wr_addr <= {cur_bank, offset[OW-1:0]};
                        ram_wr_data <= s_data;
                        offset      <= offset + 1'b1;
                        if (s_last) begin
                            state <= CLOSE;
                        end else if (offset == LAST_OFF) begin
                            state     <= DRAIN;
                            ovf_pulse <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && s_last)
                        state <= CLOSE;
                end
                CLOSE: begin
                    cur_bank <= ~cur_bank;
                    offset   <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    eth_ram_bank_tracker #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_en      (state == CLOSE),
        .set_bank    (cur_bank),
        .set_len     (offset),
        .bank_release(bank_release),
        .bank_ready  (bank_ready),
        .bank_len0   (bank_len0),
        .bank_len1   (bank_len1)
    );

`ifdef ETH_RAM_PP_STATS_EN
    // Wrapping packet and truncation counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
            ovf_cnt <= '0;
        end else begin
            if (state == CLOSE)
                pkt_cnt <= pkt_cnt + 1'b1;
            if (ovf_pulse)
                ovf_cnt <= ovf_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_ram_pingpong_ctrl.sv
// Self-checking bench for eth_ram_pingpong_ctrl.
// Define ETH_RAM_PP_STATS_EN to also check the statistics counters.
module tb_eth_ram_pingpong_ctrl;
    localparam int AW = 13;
    localparam int DW = 16;
    localparam int BD = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [1:0]    bank_ready;
    logic [AW-1:0] bank_len0;
    logic [AW-1:0] bank_len1;
    logic [1:0]    bank_release = 2'b00;
    logic          ovf_pulse;
`ifdef ETH_RAM_PP_STATS_EN
    logic [15:0]   pkt_cnt;
    logic [15:0]   ovf_cnt;
`endif

    eth_ram_pingpong_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .bank_ready  (bank_ready),
        .bank_len0   (bank_len0),
        .bank_len1   (bank_len1),
        .bank_release(bank_release),
        .ovf_pulse   (ovf_pulse)
`ifdef ETH_RAM_PP_STATS_EN
        ,
        .pkt_cnt     (pkt_cnt),
        .ovf_cnt     (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            c;
    } wr_t;
    wr_t expq[$];
    int  ovf_seen = 0;

    // Reference model: bank ownership as the read side sees it.
    logic [1:0] m_ready = 2'b00;
    logic       m_bank = 1'b0;
    int         m_len[2];
    int         m_pkts = 0;
    int         m_ovfs = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 60)
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM write monitor against the queue of expected writes.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (ovf_pulse) begin
                ovf_seen++;
                chk("ovf_at_last_slot", {19'd0, ram_wr_en, ram_wr_addr[11:0]},
                    {19'd0, 1'b1, 12'hfff});
            end
            if (ram_wr_en) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr %0h data %0h",
                             ram_wr_addr, ram_wr_data);
                end else begin
                    e = expq.pop_front();
                    chk("wr_addr", {19'd0, ram_wr_addr}, {19'd0, e.a});
                    chk("wr_data", {16'd0, ram_wr_data}, {16'd0, e.d});
                    chk("wr_latency", cyc, e.c);
                end
            end
        end
    end

    task automatic model_clear();
        m_ready = 2'b00;
        m_bank  = 1'b0;
        m_len[0] = 0;
        m_len[1] = 0;
        m_pkts  = 0;
        m_ovfs  = 0;
        expq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic pulse_release(input logic [1:0] rel);
        @(negedge clk);
        bank_release = rel;
        @(negedge clk);
        bank_release = 2'b00;
        m_ready = m_ready & ~rel;
    endtask

    task automatic wait_rdy(output bit ok);
        int t = 0;
        while (!s_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        ok = s_ready;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
        end
    endtask

    task automatic send_pkt(input int len, input bit gaps, input bit no_last);
        int base = m_bank ? BD : 0;
        bit ok;
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(3, 1)) @(negedge clk);
            end
            s_data  = DW'($urandom);
            s_last  = !no_last && (i == len - 1);
            s_valid = 1'b1;
            wait_rdy(ok);
            if (!ok) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            if (i < BD)
                expq.push_back('{AW'(base + i), s_data, cyc + 1});
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!no_last) begin
            m_ready[m_bank] = 1'b1;
            m_len[m_bank]   = (len > BD) ? BD : len;
            if (len > BD) m_ovfs++;
            m_pkts++;
            m_bank = ~m_bank;
        end
    endtask

    task automatic close_wait(input logic bank);
        int t = 0;
        while (!bank_ready[bank] && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bank_closed", {31'd0, bank_ready[bank]}, 32'd1);
        chk("writes_drained", expq.size(), 0);
    endtask

    typedef struct {
        bit         rst;
        logic [1:0] rel;
        int         len;
        logic       bank;
        logic [1:0] exp_ready;
        int         exp_len;
        int         exp_ovf;
    } row_t;

    row_t rows[6];

    initial begin
        int o0;
        logic [AW-1:0] l;
        bit ok;

        rows[0] = '{1, 2'b00, 10,   1'b0, 2'b01, 10,   0};
        rows[1] = '{0, 2'b00, 5,    1'b1, 2'b11, 5,    0};
        rows[2] = '{1, 2'b00, 5000, 1'b0, 2'b01, 4096, 1};
        rows[3] = '{1, 2'b00, 4096, 1'b0, 2'b01, 4096, 0};
        rows[4] = '{0, 2'b00, 1,    1'b1, 2'b11, 1,    0};
        rows[5] = '{0, 2'b11, 1,    1'b0, 2'b01, 1,    0};

        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, ram_wr_en}, 32'd0);
        chk("rst_bank_ready", {30'd0, bank_ready}, 32'd0);
        chk("rst_len0", {19'd0, bank_len0}, 32'd0);
        rst_n = 1'b1;

        for (int r = 0; r < 6; r++) begin
            if (rows[r].rst) do_reset();
            if (rows[r].rel != 2'b00) pulse_release(rows[r].rel);
            o0 = ovf_seen;
            send_pkt(rows[r].len, 1'b0, 1'b0);
            close_wait(rows[r].bank);
            l = rows[r].bank ? bank_len1 : bank_len0;
            chk($sformatf("row%0d_ready", r), {30'd0, bank_ready},
                {30'd0, rows[r].exp_ready});
            chk($sformatf("row%0d_len", r), {19'd0, l}, rows[r].exp_len);
            chk($sformatf("row%0d_ovf", r), ovf_seen - o0, rows[r].exp_ovf);
        end

        // Both banks owned by the reader: writer must stall until release.
        do_reset();
        send_pkt(10, 1'b0, 1'b0);
        close_wait(1'b0);
        send_pkt(5, 1'b0, 1'b0);
        close_wait(1'b1);
        s_valid = 1'b1;
        s_data  = 16'h1234;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ok = ok | s_ready;
        end
        s_valid = 1'b0;
        chk("backpressure_s_ready", {31'd0, ok}, 32'd0);
        pulse_release(2'b01);
        chk("release_clears", {30'd0, bank_ready}, 32'h2);
        chk("fill_not_yet", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        chk("fill_after_clear", {31'd0, s_ready}, 32'd1);
        send_pkt(7, 1'b0, 1'b0);
        close_wait(1'b0);
        chk("bp_ready", {30'd0, bank_ready}, 32'h3);
        chk("bp_len0", {19'd0, bank_len0}, 32'd7);

        // Reset in the middle of a packet.
        do_reset();
        send_pkt(3, 1'b0, 1'b0);
        close_wait(1'b0);
        send_pkt(300, 1'b0, 1'b1);
        #2;
        chk("partial_writes", expq.size(), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("midrst_wr_en", {31'd0, ram_wr_en}, 32'd0);
        chk("midrst_addr", {19'd0, ram_wr_addr}, 32'd0);
        chk("midrst_bank_ready", {30'd0, bank_ready}, 32'd0);
        chk("midrst_len0", {19'd0, bank_len0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        send_pkt(4, 1'b0, 1'b0);
        close_wait(1'b0);
        chk("post_rst_len0", {19'd0, bank_len0}, 32'd4);

        // Random packets with valid gaps against the bank model.
        do_reset();
        for (int p = 0; p < 24; p++) begin
            int len;
            logic [1:0] rel;
            logic b;
            len = ($urandom_range(7) == 0) ? $urandom_range(4200, 4097)
                                           : $urandom_range(200, 1);
            rel = 2'b00;
            if (m_ready[m_bank]) rel[m_bank] = 1'b1;
            if (m_ready[~m_bank] && $urandom_range(1) == 1)
                rel[~m_bank] = 1'b1;
            if (rel != 2'b00) pulse_release(rel);
            b  = m_bank;
            o0 = ovf_seen;
            send_pkt(len, 1'b1, 1'b0);
            close_wait(b);
            l = b ? bank_len1 : bank_len0;
            chk("rnd_ready", {30'd0, bank_ready}, {30'd0, m_ready});
            chk("rnd_len", {19'd0, l}, m_len[b]);
            chk("rnd_ovf", ovf_seen - o0, (len > BD) ? 1 : 0);
        end
`ifdef ETH_RAM_PP_STATS_EN
        chk("pkt_cnt", {16'd0, pkt_cnt}, m_pkts);
        chk("ovf_cnt", {16'd0, ovf_cnt}, m_ovfs);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
